// File: rtl/mult_seq_nb.sv
// Sequential shift-and-add multiplier with dual-rail operands/product and a valid/ready handshake.
// Optional accept-time rail checking is enabled by defining MULT_RAIL_CHECK_EN.
module mult_seq_nb #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     a_not,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     b_not,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic [2*WIDTH-1:0]   p_not,
  output logic                 busy,
  output logic                 rail_err
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      a_q, b_q;
  logic                  signed_q;
  logic [2*WIDTH-1:0]    acc_q, p_q;
  logic [CntW-1:0]       cnt_q;

  logic                  rail_ok;
  logic                  accept;
  logic                  last_bit;
  logic [2*WIDTH-1:0]    a_ext, pp, acc_sum;

`ifdef MULT_RAIL_CHECK_EN
  logic rail_err_q;

  assign rail_ok  = (&(a ^ a_not)) & (&(b ^ b_not));
  assign rail_err = rail_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rail_err_q <= 1'b0;
    end else if (in_valid && (state_q == StIdle) && !rail_ok) begin
      rail_err_q <= 1'b1;
    end
  end
`else
  logic unused_rails;

  assign unused_rails = ^{a_not, b_not};
  assign rail_ok      = 1'b1;
  assign rail_err     = 1'b0;
`endif

  assign accept   = in_valid && (state_q == StIdle) && rail_ok;
  assign last_bit = (cnt_q == LastCnt);

  // Signed mode weights the top multiplier bit by -2^(WIDTH-1), hence the subtraction.
  always_comb begin
    a_ext   = signed_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    pp      = b_q[cnt_q] ? (a_ext << cnt_q) : '0;
    acc_sum = (signed_q && last_bit) ? (acc_q - pp) : (acc_q + pp);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StCalc;
      StCalc: if (last_bit) state_d = StDone;
      StDone: if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      p_q      <= '0;
    end else if (accept) begin
      a_q      <= a;
      b_q      <= b;
      signed_q <= signed_mode;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (state_q == StCalc) begin
      acc_q <= acc_sum;
      cnt_q <= cnt_q + CntW'(1);
      if (last_bit) begin
        p_q <= acc_sum;
      end
    end
  end

  assign p     = p_q;
  assign p_not = ~p_q;

endmodule

// File: tb/tb_mult_seq_nb.sv
// Directed testbench for mult_seq_nb at WIDTH=8: vector table plus handshake/reset corner cases.
module tb_mult_seq_nb;

  localparam int unsigned W = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a, a_not, b, b_not;
  logic             signed_mode;
  logic             out_valid;
  logic             out_ready;
  logic [2*W-1:0]   p, p_not;
  logic             busy;
  logic             rail_err;

  int checks = 0;
  int errors = 0;

  mult_seq_nb #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .a_not      (a_not),
    .b          (b),
    .b_not      (b_not),
    .signed_mode(signed_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .p          (p),
    .p_not      (p_not),
    .busy       (busy),
    .rail_err   (rail_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic           sm;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Accept one operation, then count edges until out_valid (bounded).
  task automatic start_op(input logic sm, input logic [W-1:0] va, input logic [W-1:0] vb);
    @(negedge clk);
    a           = va;
    a_not       = ~va;
    b           = vb;
    b_not       = ~vb;
    signed_mode = sm;
    in_valid    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      if (!out_valid) lat++;
    end
  endtask

  logic [2*W-1:0] prev_p;
  logic [2*W-1:0] exp_not;
  logic [2*W-1:0] held_p;
  int             lat;
  int             seen;

  initial begin
    vecs[0] = '{sm: 1'b0, a: 8'hFF, b: 8'hFF, p: 16'hFE01};
    vecs[1] = '{sm: 1'b1, a: 8'h80, b: 8'h80, p: 16'h4000};
    vecs[2] = '{sm: 1'b1, a: 8'hFF, b: 8'h02, p: 16'hFFFE};
    vecs[3] = '{sm: 1'b0, a: 8'h03, b: 8'h05, p: 16'h000F};
    vecs[4] = '{sm: 1'b0, a: 8'h00, b: 8'hAB, p: 16'h0000};
    vecs[5] = '{sm: 1'b1, a: 8'h7F, b: 8'h7F, p: 16'h3F01};
    vecs[6] = '{sm: 1'b1, a: 8'h80, b: 8'h7F, p: 16'hC080};
    vecs[7] = '{sm: 1'b0, a: 8'h80, b: 8'h02, p: 16'h0100};
    vecs[8] = '{sm: 1'b1, a: 8'hFF, b: 8'hFF, p: 16'h0001};
    vecs[9] = '{sm: 1'b0, a: 8'h0A, b: 8'h0C, p: 16'h0078};

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    a           = '0;
    a_not       = '1;
    b           = '0;
    b_not       = '1;
    signed_mode = 1'b0;
    out_ready   = 1'b1;

    #12;
    chk("reset p", 32'(p), 32'h0000);
    chk("reset p_not", 32'(p_not), 32'hFFFF);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset rail_err", 32'(rail_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post-reset in_ready", 32'(in_ready), 32'd1);

    prev_p = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      start_op(vecs[i].sm, vecs[i].a, vecs[i].b);
      chk($sformatf("v%0d in_ready in CALC", i), 32'(in_ready), 32'd0);
      chk($sformatf("v%0d busy in CALC", i), 32'(busy), 32'd1);
      chk($sformatf("v%0d p held in CALC", i), 32'(p), 32'(prev_p));
      wait_done(lat);
      exp_not = ~vecs[i].p;
      chk($sformatf("v%0d latency", i), 32'(lat), 32'd8);
      chk($sformatf("v%0d p", i), 32'(p), 32'(vecs[i].p));
      chk($sformatf("v%0d p_not", i), 32'(p_not), 32'(exp_not));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d back to IDLE", i), 32'(in_ready), 32'd1);
      chk($sformatf("v%0d p held in IDLE", i), 32'(p), 32'(vecs[i].p));
      prev_p = vecs[i].p;
    end

    // Back-pressure, with in_valid and new operands waved around during CALC/DONE.
    out_ready = 1'b0;
    start_op(1'b0, 8'h11, 8'h0F);
    in_valid = 1'b1;
    a        = 8'hEE;
    a_not    = 8'h11;
    wait_done(lat);
    chk("bp latency", 32'(lat), 32'd8);
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp out_valid held %0d", k), 32'(out_valid), 32'd1);
      chk($sformatf("bp p held %0d", k), 32'(p), 32'h00FF);
      chk($sformatf("bp in_ready low %0d", k), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp release in_ready", 32'(in_ready), 32'd1);
    chk("bp release out_valid", 32'(out_valid), 32'd0);
    chk("bp release busy", 32'(busy), 32'd0);

    // Reset after three CALC edges aborts without delivering a product.
    start_op(1'b0, 8'hFF, 8'hFF);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort p", 32'(p), 32'h0000);
    chk("abort p_not", 32'(p_not), 32'hFFFF);
    chk("abort busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("abort no product", 32'(seen), 32'd0);
    chk("abort in_ready", 32'(in_ready), 32'd1);
    start_op(1'b0, 8'h03, 8'h05);
    wait_done(lat);
    chk("after abort latency", 32'(lat), 32'd8);
    chk("after abort p", 32'(p), 32'h000F);
    @(posedge clk);
    #1;

`ifdef MULT_RAIL_CHECK_EN
    @(negedge clk);
    a           = 8'h5A;
    a_not       = ~8'h5A ^ 8'h01;
    b           = 8'h03;
    b_not       = ~8'h03;
    signed_mode = 1'b0;
    in_valid    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("rail err set", 32'(rail_err), 32'd1);
    chk("rail in_ready", 32'(in_ready), 32'd1);
    chk("rail busy", 32'(busy), 32'd0);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("rail dropped", 32'(seen), 32'd0);
    start_op(1'b0, 8'h06, 8'h07);
    wait_done(lat);
    chk("rail good latency", 32'(lat), 32'd8);
    chk("rail good p", 32'(p), 32'h002A);
    chk("rail err sticky", 32'(rail_err), 32'd1);
    @(posedge clk);
    #1;
`else
    @(negedge clk);
    a        = 8'h5A;
    a_not    = 8'h00;
    b        = 8'h03;
    b_not    = 8'h00;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_done(lat);
    chk("no-check latency", 32'(lat), 32'd8);
    chk("no-check p", 32'(p), 32'h010E);
    chk("no-check rail_err", 32'(rail_err), 32'd0);
    @(posedge clk);
    #1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
